// File: rtl/ins_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package ins_mem_loader_pkg;

  // Opcode the control unit decodes as halt.
  localparam logic [5:0] OP_HALT = 6'b111111;

  // InsMemRW encoding of the instruction memory port.
  localparam logic INSMEM_WRITE = 1'b0;
  localparam logic INSMEM_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/ins_word_packer.sv
// Packs big-endian bytes into a 32-bit word; first byte lands in [31:24].
module ins_word_packer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next word/byte-count: clear wins over shift.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  // Shift register and byte counter with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // Asserted in the cycle the 4th byte is being shifted in.
  assign word_full = shift_en && !clear && (cnt_q == 2'd3);
  assign word_o    = word_q;

endmodule

// File: rtl/ins_mem_loader.sv
// Loads instruction memory from a length-prefixed byte stream while holding the CPU.
module ins_mem_loader
  import ins_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              InsMemRW,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // Word capacity, saturated to 9 bits since the length byte never exceeds 255.
  localparam int unsigned CAP   = (ADDR_W - 2 >= 9) ? 511 : (1 << (ADDR_W - 2));
  localparam logic [8:0]  CAP_W = 9'(CAP);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rem_q, rem_d;
  logic              err_q, err_d;

  logic        pk_clear, pk_shift, word_full;
  logic [31:0] word;
  logic        len_ok;

  ins_word_packer u_packer (
    .CLK       (CLK),
    .Reset     (Reset),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .byte_i    (in_byte),
    .word_o    (word),
    .word_full (word_full)
  );

  assign len_ok = (in_byte != 8'd0) && ({1'b0, in_byte} <= CAP_W);

  // Next-state, counter and error logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    err_d    = err_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LEN;
          err_d    = 1'b0;
          addr_d   = '0;
          rem_d    = '0;
          pk_clear = 1'b1;
        end
      end
      ST_LEN: begin
        if (in_valid) begin
          if (len_ok) begin
            rem_d   = in_byte;
            state_d = ST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DATA: begin
        pk_shift = in_valid;
        if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        addr_d = addr_q + ADDR_W'(4);
        rem_d  = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          state_d = ST_DONE;
          if (!is_halt(word[31:26])) err_d = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, address, remaining-word and error registers.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == ST_LEN) || (state_q == ST_DATA);
    InsMemRW  = (state_q == ST_WRITE) ? INSMEM_WRITE : INSMEM_READ;
    cpu_hold  = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    mem_addr  = addr_q;
    mem_wdata = word;
    err       = err_q;
  end

endmodule

// File: doc/ins_mem_loader.md
# ins_mem_loader

Sequential loader that fills instruction memory from a byte stream before the single-cycle CPU runs. It accepts a length byte followed by big-endian instruction bytes over a valid/ready handshake and packs them into 32-bit words. It writes each word through the instruction memory's `InsMemRW` port (0 = write, 1 = read) and holds the CPU off (`cpu_hold` gates `PCWre`) for the whole session. It checks that the last word loaded is `halt` (opcode 6'b111111).

## Interface
- `ADDR_W`, default 8: instruction memory byte-address width; capacity is 2^(ADDR_W-2) words.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-low reset.
- `start` input 1: request a load session; sampled only in IDLE.
- `in_valid` input 1: `in_byte` is valid.
- `in_byte` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle; a transfer occurs when `in_valid && in_ready`.
- `InsMemRW` output 1: 0 = write `mem_wdata` to `mem_addr` this cycle; 1 otherwise.
- `mem_addr` output ADDR_W: byte address, word-aligned (low 2 bits always 0).
- `mem_wdata` output 32: instruction word.
- `cpu_hold` output 1: 1 while a session is active.
- `done` output 1: one-cycle pulse at the end of a session.
- `err` output 1: sticky session error; cleared when the next `start` is accepted.

## Operation
- States:
  - IDLE: `in_ready`=0.
  - LEN: `in_ready`=1.
  - DATA: `in_ready`=1.
  - WRITE: `in_ready`=0, `InsMemRW`=0.
  - DONE: `done`=1.
- IDLE: when `start`=1, go to LEN, clear `err`, zero the address and byte counters.
- LEN: first accepted byte is word count N (0..255).
  - N=0: set `err`, go to DONE.
  - N > 2^(ADDR_W-2): set `err`, go to DONE, no writes.
  - Otherwise latch N and go to DATA.
- DATA: accept 4 bytes, shifting left, first byte into [31:24]. After the 4th byte, go to WRITE with the word presented on `mem_wdata`.
- WRITE: exactly one cycle with `InsMemRW`=0.
  - Next cycle: `mem_addr` += 4 and the remaining-word count is decremented.
  - Return to DATA if words remain, else go to DONE.
- Halt check: on the final WRITE, if `mem_wdata[31:26]` != 6'b111111, set `err`. The word is still written.
- DONE: one cycle with `done`=1, then IDLE. `cpu_hold` is 1 in LEN, DATA, WRITE and DONE, and 0 in IDLE.
- `start` outside IDLE is ignored.
- `in_valid` with `in_ready`=0: no transfer; the byte must be held by the sender (standard handshake).
- Bytes offered while in IDLE are not consumed.
- Address wrap is impossible by the N bound: the highest address written is 4·(N−1) ≤ 2^ADDR_W − 4.

## Timing
- Reset (`Reset`=0 at an edge): state IDLE and all outputs at reset values:
  - `in_ready`=0, `InsMemRW`=1, `mem_addr`=0, `mem_wdata`=0;
  - `cpu_hold`=0, `done`=0, `err`=0.
- Reset mid-session: returns to IDLE the next cycle, and no further writes occur. Words already written stay in memory and are not erased.
- `start` at edge k puts the block in LEN during cycle k+1 (`in_ready`=1, `cpu_hold`=1).
- Throughput with `in_valid` held high: 1 + 5N cycles from LEN entry to DONE entry (1 LEN + 4 DATA + 1 WRITE per word).
- `done` is asserted in the cycle after the last WRITE (or the cycle after a rejected LEN). `cpu_hold` falls one cycle after `done`.
- `in_ready` is a registered function of the state only; there is no combinational path from `in_valid` to `in_ready`.
- All outputs are registered or decoded from the state register; none depend combinationally on inputs.

## Structure
- Shared package holds:
  - opcode constant `OP_HALT` = 6'b111111, the same value the control unit decodes for halt;
  - state encoding (IDLE, LEN, DATA, WRITE, DONE as 3-bit localparams);
  - `INSMEM_WRITE`=0 and `INSMEM_READ`=1 for `InsMemRW`.
- One sub-module, `ins_word_packer`:
  - 32-bit shift register with a 2-bit byte counter;
  - `shift_en` in, `word_full` out, `clear` in.
- Top level holds the FSM, address counter and remaining-word counter.

## Test plan
- Reset, then `start`; stream 02, 20080005, FC000000 with `in_valid` always high:
  - WRITE cycles present 0x20080005 at address 0 and 0xFC000000 at address 4 with `InsMemRW`=0;
  - `done` pulses 11 cycles after LEN entry; `err`=0.
- Same session, but the last word is 0x00000000: both writes occur, `done` pulses, `err`=1.
- Length byte 00: no `InsMemRW`=0 cycle, `done` next cycle, `err`=1. With `ADDR_W`=4 and length 05: same response.
- Random `in_valid` gaps (≈50% duty) on a 3-word load: memory contents match the stream byte-exactly, and each byte is accepted exactly once.
- `Reset` asserted after the 2nd byte of word 1: IDLE next cycle; `cpu_hold`=0, `InsMemRW`=1; word 0 remains written and no write happens at address 4.
- `start` pulsed while in DATA: ignored; the session completes normally and `err` is unaffected.
